pes_ripco_sched: RTL and testbench
==================================

PES_RIPCO_SCHED -- requirements
Module: pes_ripco_sched

Interface
REQ-001 Parameter WIDTH, default 8, sets the count and terminal-count width.
REQ-002 Parameter PSC_W, default 4, sets the prescale divisor width.
REQ-003 wb_clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_i  input  1  asynchronous, active-low reset.
REQ-005 req_i  input  2  per-requester request for a counting window; level, held until done or withdrawn.
REQ-006 tc0_i, tc1_i  input  WIDTH each  terminal count for requester 0 and 1; sampled at grant.
REQ-007 psc_i  input  PSC_W  prescale value P; one count per P+1 clocks; sampled at grant.
REQ-008 abort_i  input  1  kills the active window.
REQ-009 gnt_o  output  2  one-hot grant, registered.
REQ-010 busy_o  output  1  high in LOAD or RUN.
REQ-011 tick_o  output  1  prescaler tick, high exactly in cycles where cnt_o advances at the next edge.
REQ-012 done_o  output  2  one-cycle completion pulse to the granted requester.
REQ-013 cnt_o  output  WIDTH  current window count.

Function
REQ-014 FSM states: IDLE, LOAD, RUN, DONE.
REQ-015 IDLE: if req_i nonzero, go LOAD at the next edge; else stay.
REQ-016 Arbitration: round-robin; single request wins; both requesting -> the requester not granted last wins.
REQ-017 On IDLE->LOAD: latch the winner's tc and psc_i; set gnt_o one-hot to the winner; clear cnt_o and the prescaler.
REQ-018 LOAD: latched tc == 0 -> DONE next edge; else -> RUN next edge.
REQ-019 RUN: prescaler increments each cycle from 0; tick_o = (prescaler == latched P); on a tick the prescaler returns to 0 and cnt_o increments by 1.
REQ-020 RUN: a tick with cnt_o+1 == latched tc -> DONE at that edge, cnt_o = tc.
REQ-021 Timing: req sampled at edge k -> gnt_o high after edge k; done_o high after edge k+1+tc*(P+1) (tc>0) or k+2 (tc=0).
REQ-022 DONE: for one cycle, done_o bit of the granted requester = 1 and gnt_o still asserted; then IDLE with gnt_o = 0 and the last-grant pointer updated.
REQ-023 cnt_o holds its final value in IDLE until the next LOAD.
REQ-024 abort_i, or deassertion of the granted req_i bit, in LOAD or RUN -> IDLE at the next edge; no done_o; gnt_o cleared; pointer updated; cnt_o frozen.
REQ-025 abort_i is ignored in IDLE and DONE.
REQ-026 Changes to tc*_i or psc_i after grant have no effect on the active window.
REQ-027 In IDLE, a new request is accepted in the cycle directly after DONE (back-to-back windows; no idle bubble beyond the DONE cycle).
REQ-028 Arithmetic is unsigned; cnt_o never exceeds the latched tc, so no wrap occurs. tc = 2^WIDTH-1 is legal.

Reset
REQ-029 While wb_rst_i = 0: state IDLE; gnt_o, done_o, busy_o, tick_o and cnt_o all 0; prescaler 0; pointer set so requester 0 wins the first tie.
REQ-030 Reset asserted mid-window takes effect immediately without waiting for an edge; no done_o is produced.
REQ-031 Release of reset is synchronised internally; first possible grant at the second rising edge after release.

Verification
REQ-032 Single request: req_i=01, tc0=3, P=0 sampled at edge k -> gnt_o=01 after k; cnt_o sequence 1,2,3; done_o=01 for one cycle after edge k+4; then gnt_o=00, cnt_o=3.
REQ-033 Prescale: req_i=10, tc1=2, P=2 -> tick_o every 3rd RUN cycle; done_o=10 after edge k+7.
REQ-034 Contention: req_i=11 held for three windows, tc=1, P=0 -> grants 01, 10, 01 in that order; each window is LOAD, RUN, DONE.
REQ-035 Zero count: req_i=01, tc0=0 -> LOAD then DONE; done_o=01 after edge k+2; cnt_o=0.
REQ-036 Abort: tc0=5, P=0, abort_i=1 pulsed with cnt_o=2 -> IDLE next edge; done_o never asserted; cnt_o stays 2; a pending req_i[1] is granted next.
REQ-037 Async reset: wb_rst_i=0 asserted between edges during RUN -> all outputs 0 before the next edge; after release, a request from requester 0 restarts cleanly.

Source files
------------

// File: rtl/pes_ripco_sched.sv
// Two-requester round-robin scheduler for prescaled counting windows.
// Ports: wb_clk_i/wb_rst_i, req_i, tc0_i/tc1_i, psc_i, abort_i -> gnt_o, busy_o, tick_o, done_o, cnt_o.
module pes_ripco_sched #(
  parameter int WIDTH = 8,
  parameter int PSC_W = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [1:0]       req_i,
  input  logic [WIDTH-1:0] tc0_i,
  input  logic [WIDTH-1:0] tc1_i,
  input  logic [PSC_W-1:0] psc_i,
  input  logic             abort_i,
  output logic [1:0]       gnt_o,
  output logic             busy_o,
  output logic             tick_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] cnt_o
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           nxt;
  logic             rst_n;
  logic [WIDTH-1:0] tc_q;
  logic [WIDTH-1:0] cnt_q;
  logic [PSC_W-1:0] p_q;
  logic [PSC_W-1:0] pre_q;
  logic [1:0]       gnt_q;
  logic             last_q;
  logic             win;
  logic             gidx;
  logic             kill;
  logic             tick;
  logic             fin;

  // Assert asynchronously, release on the first edge after wb_rst_i rises,
  // so the FSM can accept a request on the second edge.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) rst_n <= 1'b0;
    else           rst_n <= 1'b1;
  end

  always_comb begin
    win = 1'b0;
    unique case (1'b1)
      (req_i == 2'b10): win = 1'b1;
      (req_i == 2'b11): win = ~last_q;
      default:          win = 1'b0;
    endcase
  end

  assign gidx = gnt_q[1];
  assign kill = abort_i | ~req_i[gidx];
  assign tick = (state == RUN) && (pre_q == p_q);
  assign fin  = tick && ((cnt_q + WIDTH'(1)) == tc_q);

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (|req_i) nxt = LOAD;
      LOAD: begin
        if (kill)              nxt = IDLE;
        else if (tc_q == '0)   nxt = DONE;
        else                   nxt = RUN;
      end
      RUN: begin
        if (kill)     nxt = IDLE;
        else if (fin) nxt = DONE;
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o = (state == LOAD) || (state == RUN);
    tick_o = tick;
    done_o = (state == DONE) ? gnt_q : 2'b00;
  end

  // Abort/withdraw takes priority over a completing tick, which
  // leaves cnt_q frozen at its pre-edge value.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      tc_q   <= '0;
      p_q    <= '0;
      pre_q  <= '0;
      cnt_q  <= '0;
      gnt_q  <= 2'b00;
      last_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_i) begin
            tc_q  <= win ? tc1_i : tc0_i;
            p_q   <= psc_i;
            gnt_q <= win ? 2'b10 : 2'b01;
            cnt_q <= '0;
            pre_q <= '0;
          end
        end
        LOAD: begin
          if (kill) begin
            gnt_q  <= 2'b00;
            last_q <= gidx;
          end
        end
        RUN: begin
          if (kill) begin
            gnt_q  <= 2'b00;
            last_q <= gidx;
          end else if (tick) begin
            pre_q <= '0;
            cnt_q <= cnt_q + WIDTH'(1);
          end else begin
            pre_q <= pre_q + PSC_W'(1);
          end
        end
        DONE: begin
          gnt_q  <= 2'b00;
          last_q <= gidx;
        end
        default: ;
      endcase
    end
  end

  assign gnt_o = gnt_q;
  assign cnt_o = cnt_q;

endmodule

// File: tb/tb_pes_ripco_sched.sv
// Directed bench for pes_ripco_sched.
// Linear steps, hand-computed expectations, immediate assertions.
module tb_pes_ripco_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] req = 2'b00;
  logic [7:0] tc0 = 8'd0;
  logic [7:0] tc1 = 8'd0;
  logic [3:0] psc = 4'd0;
  logic       abort = 1'b0;
  logic [1:0] gnt;
  logic       busy;
  logic       tick;
  logic [1:0] done;
  logic [7:0] cnt;

  int total = 0;
  int bad = 0;

  logic [1:0] exp_g [3];

  pes_ripco_sched #(.WIDTH(8), .PSC_W(4)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .req_i    (req),
    .tc0_i    (tc0),
    .tc1_i    (tc1),
    .psc_i    (psc),
    .abort_i  (abort),
    .gnt_o    (gnt),
    .busy_o   (busy),
    .tick_o   (tick),
    .done_o   (done),
    .cnt_o    (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] g,
                         input logic b, input logic t,
                         input logic [1:0] d, input logic [7:0] c);
    chk({tag, ".gnt"},  32'(gnt),  32'(g));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".tick"}, 32'(tick), 32'(t));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".cnt"},  32'(cnt),  32'(c));
  endtask

  initial begin
    exp_g[0] = 2'b01;
    exp_g[1] = 2'b10;
    exp_g[2] = 2'b01;

    step();
    step();
    chk_all("rst", 2'b00, 1'b0, 1'b0, 2'b00, 8'd0);

    // release between edges, request already present
    rst = 1'b1;
    req = 2'b01;
    tc0 = 8'd3;
    psc = 4'd0;
    step();
    chk("sync.e1.gnt", 32'(gnt), 32'(2'b00));
    step();
    chk_all("single.k", 2'b01, 1'b1, 1'b0, 2'b00, 8'd0);
    tc0 = 8'd9;
    psc = 4'd5;
    step();
    chk_all("single.k1", 2'b01, 1'b1, 1'b1, 2'b00, 8'd0);
    step();
    chk("single.k2.cnt", 32'(cnt), 32'd1);
    step();
    chk("single.k3.cnt", 32'(cnt), 32'd2);
    step();
    chk_all("single.k4", 2'b01, 1'b0, 1'b0, 2'b01, 8'd3);
    req = 2'b00;
    step();
    chk_all("single.k5", 2'b00, 1'b0, 1'b0, 2'b00, 8'd3);

    // prescale: tc1=2, P=2
    req = 2'b10;
    tc1 = 8'd2;
    psc = 4'd2;
    step();
    chk_all("psc.k", 2'b10, 1'b1, 1'b0, 2'b00, 8'd0);
    step();
    chk("psc.k1.tick", 32'(tick), 32'd0);
    step();
    chk("psc.k2.tick", 32'(tick), 32'd0);
    step();
    chk_all("psc.k3", 2'b10, 1'b1, 1'b1, 2'b00, 8'd0);
    step();
    chk_all("psc.k4", 2'b10, 1'b1, 1'b0, 2'b00, 8'd1);
    step();
    chk("psc.k5.tick", 32'(tick), 32'd0);
    step();
    chk_all("psc.k6", 2'b10, 1'b1, 1'b1, 2'b00, 8'd1);
    step();
    chk_all("psc.k7", 2'b10, 1'b0, 1'b0, 2'b10, 8'd2);
    req = 2'b00;
    step();
    chk_all("psc.idle", 2'b00, 1'b0, 1'b0, 2'b00, 8'd2);

    // contention: three back-to-back windows, tc=1, P=0
    req = 2'b11;
    tc0 = 8'd1;
    tc1 = 8'd1;
    psc = 4'd0;
    for (int w = 0; w < 3; w++) begin
      step();
      chk_all($sformatf("rr%0d.load", w), exp_g[w], 1'b1, 1'b0, 2'b00, 8'd0);
      step();
      chk_all($sformatf("rr%0d.run", w), exp_g[w], 1'b1, 1'b1, 2'b00, 8'd0);
      step();
      chk_all($sformatf("rr%0d.done", w), exp_g[w], 1'b0, 1'b0, exp_g[w], 8'd1);
      if (w == 2) req = 2'b00;
      step();
      chk_all($sformatf("rr%0d.idle", w), 2'b00, 1'b0, 1'b0, 2'b00, 8'd1);
    end

    // zero terminal count: LOAD then DONE
    req = 2'b01;
    tc0 = 8'd0;
    step();
    chk_all("zero.load", 2'b01, 1'b1, 1'b0, 2'b00, 8'd0);
    step();
    chk_all("zero.done", 2'b01, 1'b0, 1'b0, 2'b01, 8'd0);
    req = 2'b00;
    step();
    chk_all("zero.idle", 2'b00, 1'b0, 1'b0, 2'b00, 8'd0);

    // abort at cnt=2 with requester 1 pending
    req = 2'b01;
    tc0 = 8'd5;
    step();
    chk("abort.load.gnt", 32'(gnt), 32'(2'b01));
    step();
    step();
    step();
    chk("abort.cnt2", 32'(cnt), 32'd2);
    abort = 1'b1;
    req = 2'b11;
    tc1 = 8'd4;
    step();
    chk_all("abort.idle", 2'b00, 1'b0, 1'b0, 2'b00, 8'd2);
    // abort still high while idle must not block the grant
    step();
    chk_all("abort.next", 2'b10, 1'b1, 1'b0, 2'b00, 8'd0);
    abort = 1'b0;
    req = 2'b10;
    step();
    step();
    chk("arst.pre.cnt", 32'(cnt), 32'd1);

    // asynchronous reset between edges during RUN
    #2;
    rst = 1'b0;
    #1;
    chk_all("arst", 2'b00, 1'b0, 1'b0, 2'b00, 8'd0);
    req = 2'b00;
    step();
    step();
    chk_all("arst.hold", 2'b00, 1'b0, 1'b0, 2'b00, 8'd0);
    rst = 1'b1;
    req = 2'b01;
    tc0 = 8'd1;
    psc = 4'd0;
    step();
    chk("restart.e1.gnt", 32'(gnt), 32'(2'b00));
    step();
    chk_all("restart.load", 2'b01, 1'b1, 1'b0, 2'b00, 8'd0);
    step();
    chk_all("restart.run", 2'b01, 1'b1, 1'b1, 2'b00, 8'd0);
    step();
    chk_all("restart.done", 2'b01, 1'b0, 1'b0, 2'b01, 8'd1);
    req = 2'b00;
    step();
    chk_all("restart.idle", 2'b00, 1'b0, 1'b0, 2'b00, 8'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
